// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state encoding
// and digit-index sizing helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the digit index counter; a single-digit datapath still needs one bit.
  function automatic int idx_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-bit ripple slice built from full-adder cells. Also exposes the carry
// into its top bit so the last digit can produce the signed overflow flag.
module addsub_digit import addsub_pkg::*; #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b_conditioned,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b_conditioned[i] ^ c[i];
      c[i+1]   = (a[i] & b_conditioned[i]) | (c[i] & (a[i] ^ b_conditioned[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes.
// Processes DIGIT bits per cycle LSB first; reports carry, overflow and optional saturation.
module addsub_serial import addsub_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             busy
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = idx_width(NDIG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  state_t             state;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic               sat_q;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [DIGIT-1:0]   a_dig;
  logic [DIGIT-1:0]   b_dig;
  logic [DIGIT-1:0]   sum_dig;
  logic               cout_dig;
  logic               cmsb_dig;
  logic [WIDTH-1:0]   s_next;
  logic               v_next;

  // Clamp to the extreme of the true sign; {C,S} is the exact result, so C is that sign.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                input logic en, input logic ovf,
                                                input logic sign);
    if (en && ovf)
      return sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return raw;
  endfunction

  assign a_dig = x_q[idx*DIGIT +: DIGIT];
  assign b_dig = y_q[idx*DIGIT +: DIGIT];

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a             (a_dig),
    .b_conditioned (b_dig),
    .cin           (carry),
    .sum           (sum_dig),
    .cout          (cout_dig),
    .c_msb         (cmsb_dig)
  );

  always_comb begin
    s_next = S;
    s_next[idx*DIGIT +: DIGIT] = sum_dig;
    v_next = cmsb_dig ^ cout_dig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      S         <= '0;
      C         <= 1'b0;
      V         <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      sat_q     <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_q      <= X;
            y_q      <= Y ^ {WIDTH{sub}};
            sat_q    <= sat;
            carry    <= sub;
            idx      <= '0;
            state    <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (idx == LAST_IDX) begin
            S         <= saturate(s_next, sat_q, v_next, cout_dig);
            C         <= cout_dig;
            V         <= v_next;
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end else begin
            S     <= s_next;
            carry <= cout_dig;
            idx   <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench: a 4-bit-digit instance and a single-digit (DIGIT=16) instance,
// directed vectors with hand-computed results.
module tb_addsub_serial;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] X         [2];
  logic [15:0] Y         [2];
  logic        sub       [2];
  logic        sat       [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] S         [2];
  logic        C         [2];
  logic        V         [2];
  logic        busy      [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(16), .DIGIT(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .X(X[0]), .Y(Y[0]), .sub(sub[0]), .sat(sat[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .S(S[0]), .C(C[0]), .V(V[0]), .busy(busy[0])
  );

  addsub_serial #(.WIDTH(16), .DIGIT(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .X(X[1]), .Y(Y[1]), .sub(sub[1]), .sat(sat[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .S(S[1]), .C(C[1]), .V(V[1]), .busy(busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    if (out_valid[d] && out_ready[d]) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        chk($sformatf("unexpected_output_dut%0d", d), 32'(S[d]), 32'hDEAD);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("S_dut%0d", d), 32'(S[d]), 32'(e.s));
        chk($sformatf("C_dut%0d", d), 32'(C[d]), 32'(e.c));
        chk($sformatf("V_dut%0d", d), 32'(V[d]), 32'(e.v));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Caller is positioned #1 after a rising edge with the DUT idle.
  task automatic issue(input int d, input logic [15:0] x, input logic [15:0] y,
                       input logic sb, input logic st, input logic [15:0] es,
                       input logic ec, input logic ev, input int lat);
    exp_t e;
    int   n;
    chk("in_ready_idle", 32'(in_ready[d]), 32'd1);
    X[d] = x; Y[d] = y; sub[d] = sb; sat[d] = st; in_valid[d] = 1'b1;
    e = '{s: es, c: ec, v: ev};
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    in_valid[d] = 1'b0; sub[d] = ~sb; sat[d] = ~st; X[d] = ~x;
    n = 0;
    while (!out_valid[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    if (out_ready[d]) begin
      @(posedge clk); #1;
      chk("out_valid_fall", 32'(out_valid[d]), 32'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; X[d] = '0; Y[d] = '0; sub[d] = 1'b0; sat[d] = 1'b0;
      out_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 32'(in_ready[d]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
      chk("rst_S", 32'(S[d]), 32'd0);
      chk("rst_CV", 32'({C[d], V[d]}), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    issue(0, 16'h1234, 16'h0101, 1'b0, 1'b0, 16'h1335, 1'b0, 1'b0, 4);
    issue(0, 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 4);
    issue(0, 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 4);
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 4);
    issue(0, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 4);
    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4);

    // Backpressure: result held for 5 cycles while a second request waits.
    out_ready[0] = 1'b0;
    issue(0, 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 16'hB4B4, 1'b0, 1'b0, 4);
    X[0] = 16'h1111; Y[0] = 16'h2222; sub[0] = 1'b0; sat[0] = 1'b0; in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_S", 32'(S[0]), 32'hB4B4);
      chk("bp_CV", 32'({C[0], V[0]}), 32'd0);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    q0.push_back('{s: 16'h3333, c: 1'b0, v: 1'b0});
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 32'(out_valid[0]), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("second_accepted_busy", 32'(busy[0]), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("second_done", 32'(out_valid[0]), 32'd0);

    // Reset two cycles into RUN: the operation must vanish.
    X[0] = 16'h1234; Y[0] = 16'h0101; sub[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrun_rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("midrun_rst_busy", 32'(busy[0]), 32'd0);
    chk("midrun_rst_S", 32'(S[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (out_valid[0]) seen++;
      end
      chk("midrun_no_out_valid", 32'(seen), 32'd0);
    end
    issue(0, 16'h1234, 16'h0101, 1'b0, 1'b0, 16'h1335, 1'b0, 1'b0, 4);

    // Single-digit instance: one-cycle latency.
    issue(1, 16'h1234, 16'h0101, 1'b0, 1'b0, 16'h1335, 1'b0, 1'b0, 1);
    issue(1, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
